gf2_mult_serial: RTL and testbench
==================================

# gf2_mult_serial

Parametrised digit-serial GF(2) polynomial multiplier with valid/ready handshakes and an optional accumulate mode. Computes the unreduced carry-less product of two W-bit operands, D bits of `in_b` per cycle, trading area against latency relative to the fully parallel single-stage multiplier. It sits under the GF(2^233) field-multiply datapath as the sub-product engine for Karatsuba splits. The accumulate mode XORs successive sub-products into one result without an external XOR stage.

## Interface
Parameters:
- `W`, 29: operand width in bits, ≥ 2.
- `D`, 8: digit width in bits, 1 ≤ D ≤ W.
- `NDIG` (localparam), ceil(W/D): number of digit cycles per product.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  block can accept operands this cycle.
- `in_a`  in  W  multiplicand polynomial, bit i = coeff of x^i.
- `in_b`  in  W  multiplier polynomial.
- `in_acc`  in  1  sampled with operands; 1 means the result is the product XOR the currently held `out_d`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes result.
- `out_d`  out  2W  result; bit 2W-1 is always 0.

## Operation
- Three-state FSM: IDLE, BUSY, DONE.
- `in_ready` is 1 in IDLE, and in DONE when `out_ready` = 1. It is 0 in BUSY. `in_ready` is combinational from state and `out_ready` only.
- Accept happens when `in_valid & in_ready` at a clock edge:
  - latch `in_a` into shift reg A (2W wide, zero-extended);
  - latch `in_b` into shift reg B (zero-padded to NDIG·D);
  - accumulator ← `in_acc` ? `out_d` : 0;
  - digit counter ← 0; state → BUSY.
- BUSY, each edge:
  - accumulator ^= XOR over j<D of (B[j] ? A<<j : 0);
  - A ← A<<D; B ← B>>D; counter++.
  - After the NDIG-th digit, `out_d` ← updated accumulator and state → DONE, in that same edge.
- DONE:
  - `out_valid` = 1 and `out_d` is held stable;
  - on `out_ready` = 1 without a new accept, go to IDLE;
  - on `out_ready` = 1 with a new accept in the same cycle, go directly to BUSY. In that case `in_acc` uses the `out_d` value being delivered.
- `out_d` keeps its last value in IDLE and BUSY. It changes only on BUSY→DONE or reset.
- Arithmetic is pure XOR/AND with no reduction. The product degree is ≤ 2W-2.
- The accumulator and A use 2W bits. Bits shifted out of A beyond bit 2W-1 are dropped; they are always zero for valid products.

## Timing
- Reset (`rst_n` = 0 at an edge) applies to all registers:
  - state = IDLE, so `in_ready` = 1;
  - `out_valid` = 0, `out_d` = 0;
  - A, B, accumulator and counter = 0.
- Reset overrides any in-flight operation, which is abandoned with no output.
- Latency: accept at edge E0 → `out_valid` high after edge E_NDIG, i.e. NDIG cycles. For W=29, D=8 this is 4 cycles.
- Throughput with `out_ready` held at 1 and `in_valid` held at 1 is one result per NDIG+1 cycles. The extra cycle comes from the DONE-state accept.
- Backpressure: DONE persists indefinitely while `out_ready` = 0. `out_d` and `out_valid` hold, and no operands are accepted.
- `in_valid` asserted during BUSY is ignored. Operands must be held by the producer until accepted.
- D = W gives NDIG = 1: a single BUSY cycle, latency 1.

## Test plan
- W=29, D=8: reset, then a=1, b=1, acc=0 → `out_d` = 0x1 with `out_valid` high exactly 4 cycles after accept. Before this, `out_d` reads 0 from reset.
- a=0x10000000, b=0x10000000 → 0x100000000000000 (x^56). Then a=b=0x1FFFFFFF → 0x155555555555555 (even bits 0..56).
- Accumulate: a=3, b=3, acc=0 → 0x5. Then a=3, b=3, acc=1 accepted in the same cycle as the 0x5 handshake → 0x0.
- Backpressure: hold `out_ready` = 0 for 10 cycles in DONE → `out_d` stable, `out_valid` = 1, `in_ready` = 0. Release → handshake completes and next accept follows per the rules.
- Reset mid-BUSY (2 cycles after accept) → next cycle IDLE, `out_valid` = 0, `out_d` = 0. A following a=5, b=7 → 0x1B.
- Parameter sweep {W,D} = {29,1}, {29,29}, {29,7}, {8,3}: 1000 random pairs with random acc and random `out_ready` stalls, compared against a bitwise carry-less model. Latency must equal NDIG every time.

Source files
------------

// File: rtl/gf2_mult_serial.sv
// Digit-serial carry-less (GF(2)) polynomial multiplier with valid/ready handshakes.
// Consumes D multiplier bits per cycle; the result can optionally be XOR-accumulated onto the held output.
module gf2_mult_serial #(
    parameter int W = 29,
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_a,
    input  logic [W-1:0]   in_b,
    input  logic           in_acc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_d
);
    localparam int NDIG = (W + D - 1) / D;
    localparam int BW   = NDIG * D;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PW   = 2 * W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] a_q, a_d;
    logic [BW-1:0] b_q, b_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] out_d_q, out_d_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          accept;
    logic          last_digit;
    logic [PW-1:0] digit_pp;
    logic [PW-1:0] acc_upd;

    // NOTE: the reset test lives inside the clocked block, so reset is synchronous
    // and every register, datapath included, is cleared on a low rst_n edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)     state_d = BUSY;
            BUSY:    if (last_digit) state_d = DONE;
            DONE:    if (out_ready)  state_d = accept ? BUSY : IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        out_valid = (state_q == DONE);
    end

    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt_q == CW'(NDIG - 1));

    // NOTE: blocking assignments here let each loop iteration build on the previous
    // one within the same evaluation; clocked state below uses non-blocking only.
    always_comb begin
        digit_pp = '0;
        for (int j = 0; j < D; j++) begin
            if (b_q[j]) begin
                digit_pp = digit_pp ^ (a_q << j);
            end
        end
    end

    assign acc_upd = acc_q ^ digit_pp;

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        out_d_d = out_d_q;
        if (accept) begin
            a_d   = PW'(in_a);
            b_d   = BW'(in_b);
            acc_d = in_acc ? out_d_q : '0;
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            acc_d = acc_upd;
            a_d   = a_q << D;
            b_d   = b_q >> D;
            cnt_d = cnt_q + CW'(1);
            if (last_digit) begin
                out_d_d = acc_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            out_d_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            out_d_q <= out_d_d;
        end
    end

    assign out_d = out_d_q;

endmodule

// File: tb/tb_gf2_mult_serial.sv
// Bench for gf2_mult_serial: directed checks on W=29/D=8, then a randomized
// parameter sweep against a plain shift-and-XOR carry-less product model.
module tb_gf2_mult_serial;
    localparam int NI = 5;
    // Instance 0 takes the directed tests; 1..4 form the parameter sweep.
    localparam logic [NI-1:0][7:0] WS = {8'd8, 8'd29, 8'd29, 8'd29, 8'd29};
    localparam logic [NI-1:0][7:0] DS = {8'd3, 8'd7, 8'd29, 8'd1, 8'd8};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n_s     [NI];
    logic        in_valid_s  [NI];
    logic        in_acc_s    [NI];
    logic        out_ready_s [NI];
    logic        in_ready_s  [NI];
    logic        out_valid_s [NI];
    logic [28:0] in_a_s      [NI];
    logic [28:0] in_b_s      [NI];
    logic [57:0] out_d_s     [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int GW = int'(WS[g]);
        localparam int GD = int'(DS[g]);
        logic [2*GW-1:0] od;
        gf2_mult_serial #(.W(GW), .D(GD)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_ready  (in_ready_s[g]),
            .in_a      (in_a_s[g][GW-1:0]),
            .in_b      (in_b_s[g][GW-1:0]),
            .in_acc    (in_acc_s[g]),
            .out_valid (out_valid_s[g]),
            .out_ready (out_ready_s[g]),
            .out_d     (od)
        );
        assign out_d_s[g] = 58'(od);
    end

    int          checks = 0;
    int          errors = 0;
    logic [57:0] held [NI];
    logic [57:0] pend [NI];
    logic [28:0] mk, ra, rb;
    logic        racc;
    int          stall;

    task automatic check(input string tag, input logic [57:0] obs, input logic [57:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [57:0] b2w(input logic b);
        return {57'b0, b};
    endfunction

    function automatic int nd(input int g);
        return (int'(WS[g]) + int'(DS[g]) - 1) / int'(DS[g]);
    endfunction

    // Reference: schoolbook carry-less product, one shifted copy of a per set bit of b.
    function automatic logic [57:0] clmul(input logic [28:0] a, input logic [28:0] b);
        logic [57:0] r;
        r = '0;
        for (int i = 0; i < 29; i++) begin
            if (b[i]) r = r ^ (58'(a) << i);
        end
        return r;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int g, input logic [28:0] a, input logic [28:0] b, input logic acc);
        int waited;
        waited = 0;
        in_valid_s[g] = 1'b1;
        in_a_s[g]     = a;
        in_b_s[g]     = b;
        in_acc_s[g]   = acc;
        #1;
        while (!in_ready_s[g] && waited < 100) begin
            tick();
            waited++;
        end
        if (waited >= 100) check("accept_timeout", b2w(in_ready_s[g]), 58'd1);
        pend[g] = clmul(a, b) ^ (acc ? held[g] : 58'd0);
        tick();
        in_valid_s[g]  = 1'b0;
        out_ready_s[g] = 1'b0;
    endtask

    task automatic finish_op(input int g, input string tag);
        int lat;
        lat = 0;
        while (!out_valid_s[g] && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 58'(lat), 58'(nd(g)));
        check({tag, "_out"}, out_d_s[g], pend[g]);
        held[g] = pend[g];
    endtask

    task automatic consume(input int g);
        out_ready_s[g] = 1'b1;
        tick();
        out_ready_s[g] = 1'b0;
        check("consume_idle", b2w(out_valid_s[g]), 58'd0);
    endtask

    initial begin
        for (int g = 0; g < NI; g++) begin
            rst_n_s[g]     = 1'b0;
            in_valid_s[g]  = 1'b0;
            in_acc_s[g]    = 1'b0;
            out_ready_s[g] = 1'b0;
            in_a_s[g]      = '0;
            in_b_s[g]      = '0;
            held[g]        = '0;
            pend[g]        = '0;
        end
        tick(2);
        for (int g = 0; g < NI; g++) rst_n_s[g] = 1'b1;
        #1;
        for (int g = 0; g < NI; g++) begin
            check("rst_in_ready", b2w(in_ready_s[g]), 58'd1);
            check("rst_out_valid", b2w(out_valid_s[g]), 58'd0);
            check("rst_out_d", out_d_s[g], 58'd0);
        end

        // Basic products.
        issue(0, 29'd1, 29'd1, 1'b0);
        finish_op(0, "one");
        consume(0);
        issue(0, 29'h1000_0000, 29'h1000_0000, 1'b0);
        finish_op(0, "x56");
        check("x56_const", out_d_s[0], 58'h100_0000_0000_0000);
        consume(0);
        issue(0, 29'h1FFF_FFFF, 29'h1FFF_FFFF, 1'b0);
        finish_op(0, "all_ones");
        check("all_ones_const", out_d_s[0], 58'h155_5555_5555_5555);
        consume(0);

        // Accumulate, with the second operand pair accepted on the DONE handshake.
        issue(0, 29'd3, 29'd3, 1'b0);
        finish_op(0, "acc0");
        check("acc0_const", out_d_s[0], 58'h5);
        check("done_no_ready", b2w(in_ready_s[0]), 58'd0);
        out_ready_s[0] = 1'b1;
        #1;
        check("done_ready", b2w(in_ready_s[0]), 58'd1);
        issue(0, 29'd3, 29'd3, 1'b1);
        check("b2b_busy_valid", b2w(out_valid_s[0]), 58'd0);
        check("b2b_busy_ready", b2w(in_ready_s[0]), 58'd0);
        in_valid_s[0] = 1'b1;   // offered during BUSY: must be ignored
        in_a_s[0]     = 29'd7;
        in_b_s[0]     = 29'd7;
        finish_op(0, "acc1");
        check("acc1_const", out_d_s[0], 58'h0);
        in_valid_s[0] = 1'b0;
        consume(0);

        // Backpressure: DONE holds while new operands wait.
        issue(0, 29'h123_4567, 29'h0AB_CDEF, 1'b0);
        finish_op(0, "bp_first");
        in_valid_s[0] = 1'b1;
        in_a_s[0]     = 29'h15A_5A5A;
        in_b_s[0]     = 29'h0F0_F0F1;
        in_acc_s[0]   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", b2w(out_valid_s[0]), 58'd1);
            check("bp_in_ready", b2w(in_ready_s[0]), 58'd0);
            check("bp_out_d", out_d_s[0], held[0]);
        end
        out_ready_s[0] = 1'b1;
        issue(0, 29'h15A_5A5A, 29'h0F0_F0F1, 1'b1);
        finish_op(0, "bp_second");
        consume(0);

        // Reset two cycles into BUSY abandons the operation and clears out_d.
        issue(0, 29'h1AB_CDEF, 29'h135_7ACE, 1'b0);
        tick(2);
        rst_n_s[0] = 1'b0;
        tick();
        rst_n_s[0] = 1'b1;
        held[0]    = '0;
        check("mid_rst_in_ready", b2w(in_ready_s[0]), 58'd1);
        check("mid_rst_valid", b2w(out_valid_s[0]), 58'd0);
        check("mid_rst_out_d", out_d_s[0], 58'd0);
        issue(0, 29'd5, 29'd7, 1'b0);
        finish_op(0, "post_rst");
        check("post_rst_const", out_d_s[0], 58'h1B);
        consume(0);

        // Parameter sweep with random operands, accumulate and output stalls.
        for (int g = 1; g < NI; g++) begin
            mk = 29'h1FFF_FFFF >> (29 - int'(WS[g]));
            for (int n = 0; n < 1000; n++) begin
                ra   = 29'($urandom) & mk;
                rb   = 29'($urandom) & mk;
                racc = 1'($urandom_range(0, 1));
                if (n > 0) begin
                    stall = $urandom_range(0, 3);
                    if (stall > 0) begin
                        tick(stall);
                        check("sweep_hold", out_d_s[g], held[g]);
                    end
                    if ($urandom_range(0, 1) == 1) out_ready_s[g] = 1'b1;
                    else consume(g);
                end
                issue(g, ra, rb, racc);
                finish_op(g, "sweep");
            end
            consume(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
